// File: rtl/muldiv_pkg.sv
// Shared encodings for the HI/LO multiply/divide unit: op codes, FSM states, iteration count.
package muldiv_pkg;

    typedef enum logic [1:0] {
        OP_MULT = 2'b00,
        OP_DIV  = 2'b01,
        OP_MTHI = 2'b10,
        OP_MTLO = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_FIX  = 2'b10
    } state_e;

    localparam int ITER_COUNT = 32;

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the execute stage and the multiply/divide unit.
interface muldiv_if;
    import muldiv_pkg::*;

    logic [31:0] A;
    logic [31:0] B;
    logic        Sign;
    op_e         op;
    logic        start;
    logic [31:0] HI;
    logic [31:0] LO;
    logic        busy;
    logic        done;

    modport master (output A, B, Sign, op, start, input HI, LO, busy, done);
    modport slave  (input A, B, Sign, op, start, output HI, LO, busy, done);

endinterface

// File: rtl/muldiv_cond_negate.sv
// Conditional two's-complement negation, used for operand magnitudes and result signs.
module cond_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);

    assign out = neg ? -in : in;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative 32x32 multiply / 32/32 divide unit writing the HI/LO pair (33-cycle latency).
module muldiv_unit
    import muldiv_pkg::*;
(
    input  logic     clk,
    input  logic     reset,
    muldiv_if.slave  bus
);

    state_e      state_r;
    logic [4:0]  cnt_r;
    op_e         op_r;
    logic        neg_res_r;
    logic        neg_rem_r;
    logic        dz_r;
    logic [31:0] b_r;
    logic [31:0] rem_r;
    logic [31:0] quo_r;
    logic [31:0] hi_r;
    logic [31:0] lo_r;
    logic        busy_r;
    logic        done_r;

    logic [31:0] a_mag_s;
    logic [31:0] b_mag_s;
    logic [63:0] prod_s;
    logic [31:0] quo_fix_s;
    logic [31:0] rem_fix_s;
    logic [32:0] sum_s;
    logic [32:0] shifted_s;
    logic [31:0] rem_sub_s;
    logic        ge_s;
    logic [31:0] rem_nxt_s;
    logic [31:0] quo_nxt_s;

    cond_negate #(.WIDTH(32)) u_neg_a (
        .neg (bus.Sign & bus.A[31]),
        .in  (bus.A),
        .out (a_mag_s)
    );

    cond_negate #(.WIDTH(32)) u_neg_b (
        .neg (bus.Sign & bus.B[31]),
        .in  (bus.B),
        .out (b_mag_s)
    );

    cond_negate #(.WIDTH(64)) u_neg_prod (
        .neg (neg_res_r),
        .in  ({rem_r, quo_r}),
        .out (prod_s)
    );

    cond_negate #(.WIDTH(32)) u_neg_quo (
        .neg (neg_res_r),
        .in  (quo_r),
        .out (quo_fix_s)
    );

    cond_negate #(.WIDTH(32)) u_neg_rem (
        .neg (neg_rem_r),
        .in  (rem_r),
        .out (rem_fix_s)
    );

    // One iteration: {rem_r,quo_r} is the running product (MULT) or the remainder/dividend pair (DIV).
    always_comb begin
        sum_s     = {1'b0, rem_r} + (quo_r[0] ? {1'b0, b_r} : 33'd0);
        shifted_s = {rem_r, quo_r[31]};
        ge_s      = (shifted_s >= {1'b0, b_r});
        rem_sub_s = shifted_s[31:0] - b_r;
        if (op_r == OP_MULT) begin
            rem_nxt_s = sum_s[32:1];
            quo_nxt_s = {sum_s[0], quo_r[31:1]};
        end else if (ge_s) begin
            rem_nxt_s = rem_sub_s;
            quo_nxt_s = {quo_r[30:0], 1'b1};
        end else begin
            rem_nxt_s = shifted_s[31:0];
            quo_nxt_s = {quo_r[30:0], 1'b0};
        end
    end

    // Control FSM with registered HI/LO, busy and done.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 5'd0;
            op_r      <= OP_MULT;
            neg_res_r <= 1'b0;
            neg_rem_r <= 1'b0;
            dz_r      <= 1'b0;
            b_r       <= 32'd0;
            rem_r     <= 32'd0;
            quo_r     <= 32'd0;
            hi_r      <= 32'd0;
            lo_r      <= 32'd0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        case (bus.op)
                            OP_MULT, OP_DIV: begin
                                op_r      <= bus.op;
                                neg_res_r <= bus.Sign & (bus.A[31] ^ bus.B[31]);
                                neg_rem_r <= bus.Sign & bus.A[31];
                                dz_r      <= (bus.B == 32'd0);
                                b_r       <= b_mag_s;
                                quo_r     <= a_mag_s;
                                rem_r     <= 32'd0;
                                cnt_r     <= 5'd0;
                                busy_r    <= 1'b1;
                                state_r   <= ST_RUN;
                            end
                            OP_MTHI: hi_r <= bus.A;
                            OP_MTLO: lo_r <= bus.A;
                            default: state_r <= ST_IDLE;
                        endcase
                    end
                end
                ST_RUN: begin
                    rem_r <= rem_nxt_s;
                    quo_r <= quo_nxt_s;
                    cnt_r <= cnt_r + 5'd1;
                    if (cnt_r == 5'(ITER_COUNT - 1)) begin
                        state_r <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    if (op_r == OP_MULT) begin
                        hi_r <= prod_s[63:32];
                        lo_r <= prod_s[31:0];
                    end else begin
                        // Divide by zero leaves the dividend as remainder, which rem_fix_s already restores to A.
                        hi_r <= rem_fix_s;
                        lo_r <= dz_r ? 32'hFFFF_FFFF : quo_fix_s;
                    end
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.HI   = hi_r;
    assign bus.LO   = lo_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed and randomized bench for muldiv_unit against an arithmetic reference model.
module tb_muldiv_unit;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   compared = 0;
    int   mismatched = 0;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    always #5 clk = ~clk;

    muldiv_if bus ();

    muldiv_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        compared++;
        assert (obs === expv) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic scramble();
        bus.A    = $urandom;
        bus.B    = $urandom;
        bus.Sign = 1'($urandom);
        bus.op   = op_e'($urandom_range(0, 3));
    endtask

    function automatic void model(input op_e op, input logic [31:0] a, input logic [31:0] b,
                                  input logic sign, output logic [31:0] hi, output logic [31:0] lo);
        int sa;
        int sb;
        logic [63:0] p;
        sa = a;
        sb = b;
        if (op == OP_MULT) begin
            if (sign) p = 64'(longint'(sa) * longint'(sb));
            else      p = {32'd0, a} * {32'd0, b};
            hi = p[63:32];
            lo = p[31:0];
        end else if (b == 32'd0) begin
            lo = 32'hFFFF_FFFF;
            hi = a;
        end else if (sign && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'd0;
        end else if (sign) begin
            lo = 32'(sa / sb);
            hi = 32'(sa % sb);
        end else begin
            lo = a / b;
            hi = a % b;
        end
    endfunction

    // inj >= 0 raises a stray start at that iteration, which must be ignored.
    task automatic run_op(input string tag, input op_e op, input logic [31:0] a, input logic [31:0] b,
                          input logic sign, input int inj);
        int early;
        logic [31:0] mh;
        logic [31:0] ml;
        @(negedge clk);
        bus.A = a; bus.B = b; bus.Sign = sign; bus.op = op; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        scramble();
        if (op == OP_MTHI || op == OP_MTLO) begin
            if (op == OP_MTHI) exp_hi = a;
            else               exp_lo = a;
            chk({tag, "_hi"}, bus.HI, exp_hi);
            chk({tag, "_lo"}, bus.LO, exp_lo);
            chk({tag, "_busy"}, bus.busy, 1'b0);
            chk({tag, "_done"}, bus.done, 1'b0);
            return;
        end
        chk({tag, "_busy"}, bus.busy, 1'b1);
        chk({tag, "_done_low"}, bus.done, 1'b0);
        early = 0;
        for (int i = 0; i < 32; i++) begin
            if (i == inj) begin
                bus.start = 1'b1;
                bus.op    = op_e'($urandom_range(0, 3));
                bus.A     = $urandom;
            end
            @(posedge clk); #1;
            bus.start = 1'b0;
            if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.HI !== exp_hi || bus.LO !== exp_lo) early++;
        end
        chk({tag, "_inflight"}, early, 0);
        @(posedge clk); #1;
        model(op, a, b, sign, mh, ml);
        exp_hi = mh;
        exp_lo = ml;
        chk({tag, "_hi"}, bus.HI, exp_hi);
        chk({tag, "_lo"}, bus.LO, exp_lo);
        chk({tag, "_done"}, bus.done, 1'b1);
        chk({tag, "_busy_end"}, bus.busy, 1'b0);
    endtask

    initial begin
        int seen;
        op_e rop;
        logic [31:0] ra;
        logic [31:0] rb;

        bus.start = 1'b0;
        scramble();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_hi", bus.HI, 32'd0);
        chk("rst_lo", bus.LO, 32'd0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        @(negedge clk);
        reset = 1'b0;

        run_op("mult_u", OP_MULT, 32'hFFFF_FFFF, 32'd2, 1'b0, -1);
        chk("mult_u_hi_const", bus.HI, 32'd1);
        chk("mult_u_lo_const", bus.LO, 32'hFFFF_FFFE);
        run_op("mult_s", OP_MULT, -32'sd3, 32'd7, 1'b1, -1);
        chk("mult_s_lo_const", bus.LO, 32'hFFFF_FFEB);
        run_op("div_s", OP_DIV, -32'sd7, 32'd2, 1'b1, -1);
        chk("div_s_lo_const", bus.LO, 32'hFFFF_FFFD);
        run_op("div_u", OP_DIV, -32'sd7, 32'd2, 1'b0, -1);
        chk("div_u_lo_const", bus.LO, 32'h7FFF_FFFC);
        run_op("div0_u", OP_DIV, 32'h1234_5678, 32'd0, 1'b0, -1);
        run_op("div0_s", OP_DIV, 32'h8765_4321, 32'd0, 1'b1, -1);
        run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, -1);
        chk("div_ovf_lo_const", bus.LO, 32'h8000_0000);
        run_op("mthi", OP_MTHI, 32'hCAFE_F00D, 32'd0, 1'b0, -1);
        run_op("mtlo", OP_MTLO, 32'h0BAD_BEEF, 32'd0, 1'b0, -1);
        run_op("mult_inj", OP_MULT, 32'h0001_2345, 32'hFFFF_0003, 1'b1, 5);
        run_op("div_inj", OP_DIV, 32'hDEAD_BEEF, 32'h0000_0100, 1'b0, 31);

        // Reset during iteration 10 of a MULT.
        @(negedge clk);
        bus.A = 32'd1234; bus.B = 32'd5678; bus.Sign = 1'b0; bus.op = OP_MULT; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        chk("abort_hi", bus.HI, exp_hi);
        chk("abort_lo", bus.LO, exp_lo);
        chk("abort_busy", bus.busy, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) seen++;
        end
        chk("abort_quiet", seen, 0);
        run_op("div_after_rst", OP_DIV, 32'd100, 32'd7, 1'b0, -1);

        // Reset wins over a simultaneous MTHI.
        @(negedge clk);
        reset = 1'b1; bus.start = 1'b1; bus.op = OP_MTHI; bus.A = 32'h5555_AAAA;
        @(posedge clk); #1;
        exp_hi = 32'd0;
        exp_lo = 32'd0;
        chk("rst_prio_hi", bus.HI, exp_hi);
        reset = 1'b0;
        bus.start = 1'b0;

        for (int n = 0; n < 24; n++) begin
            rop = op_e'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 7))
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'hFFFF_FFFF;
                default: rb = $urandom;
            endcase
            run_op($sformatf("rnd%0d", n), rop, ra, rb, 1'($urandom),
                   ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 31)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL: clock and reset. There is one clock. Reset is synchronous and active-high.
REQ-002 SHALL: clk  input  1  rising-edge clock for all state.
REQ-003 SHALL: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL: A  input  32  operand; multiplicand, dividend, or MTHI/MTLO source.
REQ-005 SHALL: B  input  32  operand; multiplier or divisor.
REQ-006 SHALL: Sign  input  1  1 = signed two's-complement operation, 0 = unsigned.
REQ-007 SHALL: op  input  2  operation select: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO.
REQ-008 SHALL: start  input  1  request; sampled only in IDLE.
REQ-009 SHALL: HI  output  32  HI register; high product or remainder.
REQ-010 SHALL: LO  output  32  LO register; low product or quotient.
REQ-011 SHALL: busy  output  1  high while an iterative operation is in flight.
REQ-012 SHALL: done  output  1  one-cycle pulse when HI/LO take a MULT/DIV result.

Function
REQ-013 SHALL: states are IDLE, RUN and FIX, registered as one state register.
REQ-014 SHALL: IDLE with start=1 and op=MULT/DIV: latch |A| and |B| (magnitudes only when Sign=1), latch the result-sign flags and op, clear the iteration counter, and go to RUN.
REQ-015 SHALL: IDLE with start=1 and op=MTHI/MTLO: write A to HI or LO at that edge, stay in IDLE, leave busy=0 and done=0.
REQ-016 SHALL: RUN performs exactly 32 iterations, one per clock: shift-add for MULT, restoring shift-subtract for DIV; the 5-bit counter reaching 31 moves to FIX.
REQ-017 SHALL: FIX applies sign correction, writes HI/LO, and returns to IDLE.
REQ-018 SHALL: MULT sign rule: 64-bit product is negated when Sign=1 and A[31]^B[31]=1.
REQ-019 SHALL: DIV sign rule: quotient is negated when Sign=1 and A[31]^B[31]=1; remainder takes the sign of A.
REQ-020 SHALL: latency: start accepted at edge N; HI/LO hold the new result after edge N+33; done=1 for exactly the cycle after edge N+33.
REQ-021 SHALL: busy=1 in RUN and FIX, 0 otherwise; the next start is accepted in the done cycle.
REQ-022 SHALL: start while busy=1 is ignored with no side effect, including for MTHI/MTLO.
REQ-023 SHALL: divide by zero (B=0) still takes the full latency, with LO=32'hFFFFFFFF and HI=A for both Sign values.
REQ-024 SHALL: signed overflow (Sign=1, A=32'h80000000, B=32'hFFFFFFFF) gives LO=32'h80000000, HI=0.
REQ-025 SHALL: HI/LO are not modified in RUN; they hold their previous values until FIX.
REQ-026 SHALL: A, B, Sign and op are don't-care after the start edge; only latched copies are used.

Reset
REQ-027 SHALL: reset=1 at a rising edge forces state=IDLE, HI=0, LO=0, busy=0, done=0, and counter=0.
REQ-028 SHALL: reset mid-operation (RUN or FIX) aborts the operation with no HI/LO write and no done pulse.
REQ-029 SHALL: reset takes priority over start in the same cycle.

Structure
REQ-030 SHALL: shared package muldiv_pkg holds the op encodings (OP_MULT, OP_DIV, OP_MTHI, OP_MTLO), the state encoding, and ITER_COUNT=32.
REQ-031 SHALL: one sub-module, cond_negate (32-bit, parameterisable width, combinational: out = neg ? -in : in), used for the operand-magnitude and result-sign steps; the 64-bit product uses a width-64 instance.
REQ-032 SHALL: muldiv_unit sits beside the ALU in the execute path; its only consumer-visible results are HI/LO, selected downstream by MFHI/MFLO.

Verification
REQ-033 SHALL: MULT Sign=0, A=32'hFFFFFFFF, B=2 -> after 33 edges HI=1, LO=32'hFFFFFFFE, done pulses once.
REQ-034 SHALL: MULT Sign=1, A=-3, B=7 -> HI=32'hFFFFFFFF, LO=32'hFFFFFFEB.
REQ-035 SHALL: DIV Sign=1, A=-7, B=2 -> LO=32'hFFFFFFFD, HI=32'hFFFFFFFF; with Sign=0 and the same bits -> LO=32'h7FFFFFFC, HI=1.
REQ-036 SHALL: DIV B=0, A=32'h12345678 -> LO=32'hFFFFFFFF, HI=32'h12345678 after full latency; overflow case -> LO=32'h80000000, HI=0.
REQ-037 SHALL: MTHI A=32'hCAFEF00D in IDLE -> HI updated next cycle with busy=0, done=0; MTLO issued while busy -> LO unchanged.
REQ-038 SHALL: reset asserted at iteration 10 of a MULT -> HI=LO=0, busy=0, no done pulse; a new DIV issued after reset completes correctly.
